// File: rtl/rr_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rr_bus_ctrl
// Purpose  : Bus-side burst controller behind a 4-way round-robin arbiter.
//            A single grant sampled in IDLE latches the owning client and its
//            burst length. The block then streams len+1 beats of that client's
//            live data onto a valid/ready bus, acks each accepted beat back to
//            the client, and pulses that client's done line once the final
//            beat has been taken.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DW                 width of client and bus data
//   LW                 width of burst-length fields (burst = len+1 beats)
// Ports
//   clk                rising-edge clock
//   rst                asynchronous active-high reset
//   gnt0..gnt3         one-hot grants from the arbiter
//   len0..len3         per-client burst length minus one
//   data0..data3       per-client live beat data
//   out_valid          a beat is offered (XFER state)
//   out_ready          downstream accepts the beat
//   out_data           beat data, data[src]
//   out_src            owning client index (0 outside XFER)
//   out_last           final beat of the burst
//   ack0..ack3         beat accepted for client N
//   done0..done3       one-cycle burst-complete pulse
//   busy               transfer in progress (XFER or DONE)
//   err                sticky: two or more grants seen together in IDLE
// ============================================================================
module rr_bus_ctrl #(
  parameter int DW = 8,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gnt3,
  input  logic          gnt2,
  input  logic          gnt1,
  input  logic          gnt0,
  input  logic [LW-1:0] len3,
  input  logic [LW-1:0] len2,
  input  logic [LW-1:0] len1,
  input  logic [LW-1:0] len0,
  input  logic [DW-1:0] data3,
  input  logic [DW-1:0] data2,
  input  logic [DW-1:0] data1,
  input  logic [DW-1:0] data0,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_src,
  output logic          out_last,
  output logic          ack3,
  output logic          ack2,
  output logic          ack1,
  output logic          ack0,
  output logic          done3,
  output logic          done2,
  output logic          done1,
  output logic          done0,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    src, src_nxt;
  logic [LW-1:0] cnt, cnt_nxt;
  logic          err_q, err_nxt;

  logic [3:0]    gnt_vec;
  logic          gnt_multi;
  logic          gnt_one;
  logic [1:0]    gnt_idx;
  logic [LW-1:0] gnt_len;
  logic [DW-1:0] data_sel;
  logic          accept;
  logic          in_xfer;
  logic          in_done;

  assign gnt_vec   = {gnt3, gnt2, gnt1, gnt0};
  // Clearing the lowest set bit leaves something only if 2+ bits were set.
  assign gnt_multi = (gnt_vec & (gnt_vec - 4'd1)) != 4'd0;
  assign gnt_one   = (gnt_vec != 4'd0) && !gnt_multi;

  always_comb begin
    gnt_idx = 2'd0;
    case (gnt_vec)
      4'b0010: gnt_idx = 2'd1;
      4'b0100: gnt_idx = 2'd2;
      4'b1000: gnt_idx = 2'd3;
      default: gnt_idx = 2'd0;
    endcase
  end

  always_comb begin
    gnt_len = len0;
    case (gnt_idx)
      2'd1:    gnt_len = len1;
      2'd2:    gnt_len = len2;
      2'd3:    gnt_len = len3;
      default: gnt_len = len0;
    endcase
  end

  always_comb begin
    data_sel = data0;
    case (src)
      2'd1:    data_sel = data1;
      2'd2:    data_sel = data2;
      2'd3:    data_sel = data3;
      default: data_sel = data0;
    endcase
  end

  assign in_xfer = (state == XFER);
  assign in_done = (state == DONE);
  assign accept  = in_xfer && out_ready;

  // State register and latched burst context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      src   <= 2'd0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      src   <= src_nxt;
      cnt   <= cnt_nxt;
      err_q <= err_nxt;
    end
  end

  // Next-state logic. Grants are only looked at in IDLE; src and cnt are
  // frozen outside IDLE except for the per-beat countdown.
  always_comb begin
    state_nxt = state;
    src_nxt   = src;
    cnt_nxt   = cnt;
    err_nxt   = err_q;
    case (state)
      IDLE: begin
        if (gnt_multi) begin
          err_nxt = 1'b1;
        end else if (gnt_one) begin
          src_nxt   = gnt_idx;
          cnt_nxt   = gnt_len;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          if (cnt == '0) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt - LW'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The registers already clear asynchronously; only the data mux would
  // otherwise leak client data during reset, so it is gated explicitly.
  assign out_valid = in_xfer;
  assign out_data  = rst ? '0 : data_sel;
  assign out_src   = in_xfer ? src : 2'd0;
  assign out_last  = in_xfer && (cnt == '0);
  assign busy      = in_xfer || in_done;
  assign err       = err_q;

  assign ack0  = accept && (src == 2'd0);
  assign ack1  = accept && (src == 2'd1);
  assign ack2  = accept && (src == 2'd2);
  assign ack3  = accept && (src == 2'd3);

  assign done0 = in_done && (src == 2'd0);
  assign done1 = in_done && (src == 2'd1);
  assign done2 = in_done && (src == 2'd2);
  assign done3 = in_done && (src == 2'd3);

endmodule
`default_nettype wire

// File: tb/tb_rr_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_bus_ctrl
// Purpose  : Directed self-checking bench for rr_bus_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gnt;
  logic [3:0] len  [4];
  logic [7:0] data [4];
  logic       out_ready;

  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_src;
  logic       out_last;
  logic [3:0] ack;
  logic [3:0] done;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;
  int acks     = 0;

  always #5 clk = ~clk;

  rr_bus_ctrl #(.DW(8), .LW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .gnt3      (gnt[3]),
    .gnt2      (gnt[2]),
    .gnt1      (gnt[1]),
    .gnt0      (gnt[0]),
    .len3      (len[3]),
    .len2      (len[2]),
    .len1      (len[1]),
    .len0      (len[0]),
    .data3     (data[3]),
    .data2     (data[2]),
    .data1     (data[1]),
    .data0     (data[0]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .ack3      (ack[3]),
    .ack2      (ack[2]),
    .ack1      (ack[1]),
    .ack0      (ack[0]),
    .done3     (done[3]),
    .done2     (done[2]),
    .done1     (done[1]),
    .done0     (done[0]),
    .busy      (busy),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Land 1 time unit after the rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    gnt       = 4'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      len[i]  = 4'd0;
      data[i] = 8'h55;
    end
    #1;
    // ---------------- reset state ----------------
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_src",   32'(out_src),   32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_ack",   32'(ack),       32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_err",   32'(err),       32'd0);
    tick();
    tick();
    rst = 1'b0;

    // ---------------- 3-beat burst on client 0 ----------------
    gnt = 4'b0001; len[0] = 4'd2; data[0] = 8'h10; out_ready = 1'b1;
    tick();
    gnt = 4'd0; #1;
    chk("t1_b1_valid", 32'(out_valid), 32'd1);
    chk("t1_b1_data",  32'(out_data),  32'h10);
    chk("t1_b1_src",   32'(out_src),   32'd0);
    chk("t1_b1_last",  32'(out_last),  32'd0);
    chk("t1_b1_ack",   32'(ack),       32'b0001);
    chk("t1_b1_busy",  32'(busy),      32'd1);
    tick();
    data[0] = 8'h11; #1;
    chk("t1_b2_data",  32'(out_data),  32'h11);
    chk("t1_b2_last",  32'(out_last),  32'd0);
    tick();
    data[0] = 8'h12; #1;
    chk("t1_b3_data",  32'(out_data),  32'h12);
    chk("t1_b3_last",  32'(out_last),  32'd1);
    chk("t1_b3_ack",   32'(ack),       32'b0001);
    tick();
    chk("t1_done_valid", 32'(out_valid), 32'd0);
    chk("t1_done",       32'(done),      32'b0001);
    chk("t1_done_busy",  32'(busy),      32'd1);
    tick();
    chk("t1_idle_done", 32'(done), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // ---------------- 1-beat burst on client 2 ----------------
    gnt = 4'b0100; len[2] = 4'd0; data[2] = 8'h2A;
    tick();
    gnt = 4'd0; #1;
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_data",  32'(out_data),  32'h2A);
    chk("t2_src",   32'(out_src),   32'd2);
    chk("t2_last",  32'(out_last),  32'd1);
    chk("t2_ack",   32'(ack),       32'b0100);
    chk("t2_busy1", 32'(busy),      32'd1);
    tick();
    chk("t2_done",  32'(done),      32'b0100);
    chk("t2_busy2", 32'(busy),      32'd1);
    chk("t2_ack_after", 32'(ack),   32'd0);
    tick();
    chk("t2_idle_busy", 32'(busy), 32'd0);
    chk("t2_idle_done", 32'(done), 32'd0);

    // ---------------- stalled 2-beat burst on client 1 ----------------
    gnt = 4'b0010; len[1] = 4'd1; data[1] = 8'hA0;
    tick();
    gnt = 4'd0; out_ready = 1'b0; #1;
    chk("t3_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("t3_stall_valid", 32'(out_valid), 32'd1);
      chk("t3_stall_data",  32'(out_data),  32'hA0);
      chk("t3_stall_src",   32'(out_src),   32'd1);
      chk("t3_stall_last",  32'(out_last),  32'd0);
      chk("t3_stall_ack",   32'(ack),       32'd0);
      tick();
    end
    out_ready = 1'b1; #1;
    chk("t3_b1_data", 32'(out_data), 32'hA0);
    chk("t3_b1_last", 32'(out_last), 32'd0);
    acks += int'(ack[1]);
    tick();
    data[1] = 8'hA1; #1;
    chk("t3_b2_data", 32'(out_data), 32'hA1);
    chk("t3_b2_last", 32'(out_last), 32'd1);
    acks += int'(ack[1]);
    tick();
    chk("t3_done",  32'(done), 32'b0010);
    chk("t3_acks",  32'(acks), 32'd2);
    tick();

    // ---------------- double grant, then single grant while err ----------------
    gnt = 4'b1001; len[3] = 4'd0; data[3] = 8'h3C;
    tick();
    gnt = 4'd0; #1;
    chk("t4_err",   32'(err),       32'd1);
    chk("t4_valid", 32'(out_valid), 32'd0);
    chk("t4_busy",  32'(busy),      32'd0);
    tick();
    chk("t4_valid2", 32'(out_valid), 32'd0);
    gnt = 4'b1000;
    tick();
    gnt = 4'd0; #1;
    chk("t4_g3_valid", 32'(out_valid), 32'd1);
    chk("t4_g3_src",   32'(out_src),   32'd3);
    chk("t4_g3_data",  32'(out_data),  32'h3C);
    chk("t4_g3_last",  32'(out_last),  32'd1);
    chk("t4_g3_ack",   32'(ack),       32'b1000);
    tick();
    chk("t4_done", 32'(done), 32'b1000);
    chk("t4_err2", 32'(err),  32'd1);
    tick();
    chk("t4_idle_src", 32'(out_src), 32'd0);
    chk("t4_err3",     32'(err),     32'd1);

    // ---------------- reset mid-burst ----------------
    gnt = 4'b0001; len[0] = 4'd3; data[0] = 8'h20;
    tick();
    gnt = 4'd0; #1;
    chk("t5_b1_data", 32'(out_data), 32'h20);
    tick();
    data[0] = 8'h21; #1;
    chk("t5_b2_valid", 32'(out_valid), 32'd1);
    rst = 1'b1; #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_data",  32'(out_data),  32'd0);
    chk("t5_rst_ack",   32'(ack),       32'd0);
    chk("t5_rst_busy",  32'(busy),      32'd0);
    chk("t5_rst_err",   32'(err),       32'd0);
    chk("t5_rst_done",  32'(done),      32'd0);
    tick();
    chk("t5_rst_done2", 32'(done), 32'd0);
    rst = 1'b0;
    gnt = 4'b0001; len[0] = 4'd1; data[0] = 8'h30;
    tick();
    gnt = 4'd0; #1;
    chk("t5_new_valid", 32'(out_valid), 32'd1);
    chk("t5_new_data",  32'(out_data),  32'h30);
    chk("t5_new_last",  32'(out_last),  32'd0);
    tick();
    chk("t5_new_last2", 32'(out_last), 32'd1);
    tick();
    chk("t5_new_done", 32'(done), 32'b0001);
    tick();

    // ---------------- round-robin sequence ----------------
    for (int i = 0; i < 4; i++) begin
      gnt = 4'(1 << i); len[i] = 4'd1; data[i] = 8'(8'hC0 + i);
      tick();
      gnt = 4'd0; #1;
      chk("t6_valid", 32'(out_valid), 32'd1);
      chk("t6_src",   32'(out_src),   32'(i));
      chk("t6_data",  32'(out_data),  32'(8'hC0 + i));
      chk("t6_last1", 32'(out_last),  32'd0);
      tick();
      chk("t6_last2", 32'(out_last),  32'd1);
      chk("t6_src2",  32'(out_src),   32'(i));
      tick();
      chk("t6_gap1", 32'(out_valid), 32'd0);
      chk("t6_done", 32'(done),      32'(1 << i));
      tick();
      chk("t6_gap2", 32'(out_valid), 32'd0);
      chk("t6_idle_busy", 32'(busy), 32'd0);
    end

    // ---------------- max length: 16 beats, no wrap ----------------
    gnt = 4'b0100; len[2] = 4'hF; data[2] = 8'h00;
    tick();
    gnt = 4'd0; #1;
    acks = 0;
    for (int i = 0; i < 16; i++) begin
      chk("t7_valid", 32'(out_valid), 32'd1);
      chk("t7_last",  32'(out_last),  32'(i == 15));
      acks += int'(ack[2]);
      tick();
    end
    chk("t7_acks", 32'(acks), 32'd16);
    chk("t7_done", 32'(done), 32'b0100);
    tick();
    chk("t7_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_bus_ctrl.md
RR_BUS_CTRL -- requirements
Module: rr_bus_ctrl

Interface
- REQ-001 Parameter DW, default 8, width of client and bus data.
- REQ-002 Parameter LW, default 4, width of burst-length fields.
- REQ-003 clk  input  1  single clock; all state changes on rising edge.
- REQ-004 rst  input  1  reset, asynchronous, active-high.
- REQ-005 gnt3, gnt2, gnt1, gnt0  input  1 each  one-hot grants from the 4-way round-robin arbiter.
- REQ-006 len3, len2, len1, len0  input  LW each  per-client burst length; transfer is lenN+1 beats.
- REQ-007 data3, data2, data1, data0  input  DW each  per-client beat data, presented live by each client.
- REQ-008 out_valid  output  1  a bus beat is offered.
- REQ-009 out_ready  input  1  downstream accepts the beat.
- REQ-010 out_data  output  DW  beat data.
- REQ-011 out_src  output  2  index of the owning client.
- REQ-012 out_last  output  1  the final beat of a burst.
- REQ-013 ack3, ack2, ack1, ack0  output  1 each  beat accepted for client N; client advances its data next cycle.
- REQ-014 done3, done2, done1, done0  output  1 each  one-cycle burst-complete pulse.
- REQ-015 busy  output  1  a transfer is in progress.
- REQ-016 err  output  1  sticky grant-protocol error.

Function
- REQ-017 Block SHALL implement FSM states IDLE, XFER, DONE; reset state IDLE.
- REQ-018 In IDLE, at a rising edge with exactly one gntN high, block SHALL latch src=N and cnt=lenN, then enter XFER.
- REQ-019 In IDLE with no gnt high, block SHALL remain in IDLE.
- REQ-020 In IDLE with two or more gnt high, block SHALL set err, start no transfer, and remain in IDLE.
- REQ-021 err SHALL stay set until reset.
- REQ-022 While err is set, later single grants SHALL still be served.
- REQ-023 out_valid SHALL be 1 exactly while in XFER, so the first beat is offered in the cycle after the grant-sampling edge.
- REQ-024 out_data SHALL be combinationally data[src].
- REQ-025 out_src SHALL equal src in XFER and 0 otherwise.
- REQ-026 A beat SHALL be accepted at a rising edge where out_valid and out_ready are both 1.
- REQ-027 ackN SHALL be out_valid & out_ready & (src==N), combinational, at most one ack high.
- REQ-028 On each accepted beat with cnt>0, cnt SHALL decrement by 1.
- REQ-029 out_last SHALL be 1 when in XFER and cnt==0.
- REQ-030 An accepted beat with out_last=1 SHALL move the FSM to DONE.
- REQ-031 out_ready low SHALL stall the burst: out_valid, out_data source, cnt and src are held, with no limit on stall length.
- REQ-032 In DONE, doneN for the latched src SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
- REQ-033 Grants SHALL NOT be sampled in XFER or DONE.
- REQ-034 Grant changes or drops during XFER SHALL NOT alter src, cnt or the burst.
- REQ-035 Back-to-back bursts SHALL have a minimum gap of 2 cycles without out_valid (DONE plus IDLE sample).
- REQ-036 busy SHALL be 1 in XFER and DONE.
- REQ-037 lenN=0 SHALL give a 1-beat burst with out_last=1 on that beat.
- REQ-038 lenN=2^LW-1 SHALL give 2^LW beats, with no wrap-around of cnt.

Reset
- REQ-039 Asserting rst SHALL immediately, without waiting for clk, force state IDLE and clear src, cnt and err.
- REQ-040 During rst, all outputs SHALL read 0.
- REQ-041 rst mid-burst SHALL abort the burst with no done pulse.
- REQ-042 After rst release, the first grant-sampling edge SHALL be the first rising edge with rst low.

Verification
- REQ-043 gnt0=1, len0=2, data0 stepping 0x10/0x11/0x12 on ack0, out_ready=1 -> 3 beats 0x10,0x11,0x12, out_src=0, out_last on third beat, done0 pulse next cycle.
- REQ-044 gnt2=1, len2=0, out_ready=1 -> single beat with out_last=1, ack2 once, done2 once, busy high for 2 cycles.
- REQ-045 gnt1=1, len1=1, out_ready low for 3 cycles mid-burst -> out_valid held, out_data/out_src stable, no ack1 while stalled, exactly 2 acks total.
- REQ-046 gnt0 and gnt3 both high in IDLE -> err=1, no out_valid. Then gnt3 alone, len3=0 -> 1-beat burst on src 3 completes, err still 1.
- REQ-047 rst asserted during beat 2 of a len=3 burst -> outputs 0 immediately, no done pulse. After release, a new grant starts a fresh burst from beat 1.
- REQ-048 Round-robin sequence gnt0, gnt1, gnt2, gnt3, each with len=1, out_ready=1 -> 4 bursts in grant order, out_src 0,1,2,3, ≥2-cycle gap between bursts.
